rst_seq_gen: RTL and testbench

Parametrised tick generator and multi-channel power-up/power-down sequencer. It divides the system clock into a periodic single-cycle tick. Using that tick as its timebase, it releases `NUM_CH` enable/reset outputs in order, with a programmable delay before each one, and removes them in reverse order on shutdown. It sits next to the clock/PLL logic and drives camera power enables, I2C master reset and ISP block resets from one place, replacing hard-coded per-signal timers.

---
 rtl/rst_seq_gen.sv | 184 ++++++++++++++++++
 tb/tb_rst_seq_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: divides clk into a periodic tick and uses it to release
// NUM_CH enables/resets in order with per-channel delays, removing them
// in reverse order (one per tick) on shutdown.

// Per-channel output stage: maps logical activity onto the pin polarity.
module rst_seq_gen_pol #(
    parameter logic POL = 1'b1
) (
    input  logic act,
    output logic ch_out
);
    // active-high enable passes activity through, active-low reset inverts it
    assign ch_out = POL ? act : ~act;
endmodule

module rst_seq_gen #(
    parameter int                      CLK_HZ  = 100_000_000,
    parameter int                      TICK_HZ = 1000,
    parameter int                      NUM_CH  = 4,
    parameter int                      DLY_W   = 16,
    parameter logic [NUM_CH*DLY_W-1:0] CH_DLY  = '0,
    parameter logic [NUM_CH-1:0]       CH_POL  = '1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         restart,
    input  logic                         shutdown,
    output logic                         tick,
    output logic [NUM_CH-1:0]            ch_out,
    output logic                         seq_busy,
    output logic                         seq_done,
    output logic [$clog2(NUM_CH+1)-1:0]  step_idx
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(NUM_CH + 1);
    // delay table padded to a power of two so idx can index it directly
    localparam int TBL = 1 << IW;
    localparam logic [DW-1:0] DCNT_MAX = DW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("rst_seq_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
            $error("rst_seq_gen: NUM_CH must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DONE = 2'd1,
        ST_DOWN = 2'd2,
        ST_OFF  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [DW-1:0]     dcnt;
    logic [IW-1:0]     idx, idx_d;
    logic [DLY_W-1:0]  dly_cnt, dly_d;
    logic [NUM_CH-1:0] act, act_d;
    logic [TBL-1:0][DLY_W-1:0] dly_tab;
    logic [DLY_W-1:0]  cur_dly;
    logic              step_hit;

    // unpack the flat delay parameter; unused slots read as zero
    for (genvar g = 0; g < TBL; g++) begin : g_tab
        if (g < NUM_CH) begin : g_real
            assign dly_tab[g] = CH_DLY[g*DLY_W +: DLY_W];
        end else begin : g_pad
            assign dly_tab[g] = '0;
        end
    end

    assign cur_dly = dly_tab[idx];

    // a step finishes at once for zero delay, otherwise on the tick that
    // brings the elapsed count up to the programmed value
    assign step_hit = (cur_dly == '0) ||
                      (tick && ((dly_cnt + DLY_W'(1)) == cur_dly));

    // free-running divider; tick is registered, one cycle after the wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt <= '0;
            tick <= 1'b0;
        end else begin
            dcnt <= (dcnt == DCNT_MAX) ? '0 : dcnt + DW'(1);
            tick <= (dcnt == DCNT_MAX);
        end
    end

    // sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_UP;
            idx     <= '0;
            dly_cnt <= '0;
            act     <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            dly_cnt <= dly_d;
            act     <= act_d;
        end
    end

    // next-state: normal progress first, then shutdown/restart overrides
    always_comb begin
        state_d = state;
        idx_d   = idx;
        dly_d   = dly_cnt;
        act_d   = act;

        case (state)
            ST_UP: begin
                if (step_hit) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx == IW'(i)) act_d[i] = 1'b1;
                    end
                    idx_d = idx + IW'(1);
                    dly_d = '0;
                    if (idx == IW'(NUM_CH - 1)) state_d = ST_DONE;
                end else if (tick) begin
                    dly_d = dly_cnt + DLY_W'(1);
                end
            end
            ST_DONE: begin
                act_d = '1;
            end
            ST_DOWN: begin
                if (act == '0) begin
                    state_d = ST_OFF;
                end else if (tick) begin
                    // channels are set contiguously from 0, so the highest
                    // active one sits at idx-1
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx == IW'(i + 1)) act_d[i] = 1'b0;
                    end
                    idx_d = idx - IW'(1);
                end
            end
            ST_OFF: begin
                if (!shutdown) begin
                    state_d = ST_UP;
                    idx_d   = '0;
                    dly_d   = '0;
                    act_d   = '0;
                end
            end
            default: begin
                state_d = ST_UP;
                idx_d   = '0;
                dly_d   = '0;
                act_d   = '0;
            end
        endcase

        // shutdown keeps any step completion this cycle but redirects the
        // state; restart only counts while shutdown is low
        if (shutdown) begin
            if (state == ST_UP || state == ST_DONE) state_d = ST_DOWN;
        end else if (restart) begin
            state_d = ST_UP;
            idx_d   = '0;
            dly_d   = '0;
            act_d   = '0;
        end
    end

    // per-channel polarity stages
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rst_seq_gen_pol #(.POL(CH_POL[g])) u_pol (
            .act    (act[g]),
            .ch_out (ch_out[g])
        );
    end

    assign seq_busy = (state == ST_UP) || (state == ST_DOWN);
    assign seq_done = (state == ST_DONE);
    assign step_idx = idx;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: DIV=10, three channels with delays {3,0,2} and
// polarity 101. Expected output snapshots and tick cycles are queued by the
// stimulus; monitors pop and compare whenever the outputs change or tick fires.
module tb_rst_seq_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       restart = 1'b0;
    logic       shutdown = 1'b0;
    logic       tick;
    logic [2:0] ch_out;
    logic       seq_busy;
    logic       seq_done;
    logic [1:0] step_idx;

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [31:0] c;
        logic [2:0]  ch;
        logic        busy;
        logic        done;
        logic [1:0]  step;
    } snap_t;

    snap_t snap_q[$];
    int    tick_q[$];

    rst_seq_gen #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .NUM_CH  (3),
        .DLY_W   (8),
        .CH_DLY  ({8'd3, 8'd0, 8'd2}),
        .CH_POL  (3'b101)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart  (restart),
        .shutdown (shutdown),
        .tick     (tick),
        .ch_out   (ch_out),
        .seq_busy (seq_busy),
        .seq_done (seq_done),
        .step_idx (step_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] ch, input logic b,
                        input logic d, input logic [1:0] s);
        snap_t e;
        e.c = c; e.ch = ch; e.busy = b; e.done = d; e.step = s;
        snap_q.push_back(e);
    endtask

    // return just after the negedge where cyc reaches n
    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    // output-change monitor
    initial begin : mon_snap
        snap_t cur, prv, exp;
        bit    first;
        first = 1'b1;
        prv   = '0;
        forever begin
            @(negedge clk);
            cur.c = cyc; cur.ch = ch_out; cur.busy = seq_busy;
            cur.done = seq_done; cur.step = step_idx;
            if (first || cur.ch != prv.ch || cur.busy != prv.busy ||
                cur.done != prv.done || cur.step != prv.step) begin
                first = 1'b0;
                nvec++;
                if (snap_q.size() == 0) begin
                    nerr++;
                    $display("FAIL snap unexpected: got cyc=%0d ch=%b busy=%b done=%b step=%0d, want no change",
                             cur.c, cur.ch, cur.busy, cur.done, cur.step);
                end else begin
                    exp = snap_q.pop_front();
                    if (cur != exp) begin
                        nerr++;
                        $display("FAIL snap: got cyc=%0d ch=%b busy=%b done=%b step=%0d, want cyc=%0d ch=%b busy=%b done=%b step=%0d",
                                 cur.c, cur.ch, cur.busy, cur.done, cur.step,
                                 exp.c, exp.ch, exp.busy, exp.done, exp.step);
                    end
                end
            end
            prv = cur;
        end
    end

    // tick monitor
    initial begin : mon_tick
        int exp_c;
        forever begin
            @(negedge clk);
            if (tick) begin
                nvec++;
                if (tick_q.size() == 0) begin
                    nerr++;
                    $display("FAIL tick unexpected: got tick at cyc=%0d, want none", cyc);
                end else begin
                    exp_c = tick_q.pop_front();
                    if (cyc != exp_c) begin
                        nerr++;
                        $display("FAIL tick: got cyc=%0d, want cyc=%0d", cyc, exp_c);
                    end
                end
            end
        end
    end

    initial begin : stim
        // reset values, then the first up-sequence (ch0 after 2 ticks,
        // ch1 the next cycle, ch2 three ticks later)
        push(1,   3'b010, 1, 0, 0);
        push(23,  3'b011, 1, 0, 1);
        push(24,  3'b001, 1, 0, 2);
        push(53,  3'b101, 0, 1, 3);
        for (int k = 1; k <= 16; k++) tick_q.push_back(2 + 10 * k);

        #1 reset_n = 1'b0;
        at_neg(2);
        reset_n = 1'b1;

        // restart together with shutdown in DONE: down-sequence, restart ignored
        push(61, 3'b101, 1, 0, 3);
        push(63, 3'b001, 1, 0, 2);
        push(73, 3'b011, 1, 0, 1);
        push(83, 3'b010, 1, 0, 0);
        push(84, 3'b010, 0, 0, 0);
        at_neg(60);
        shutdown = 1'b1;
        restart  = 1'b1;
        at_neg(61);
        restart  = 1'b0;

        // release shutdown in OFF: up-sequence from step 0
        push(91,  3'b010, 1, 0, 0);
        push(103, 3'b011, 1, 0, 1);
        push(104, 3'b001, 1, 0, 2);
        at_neg(90);
        shutdown = 1'b0;

        // restart after ch0/ch1 are set: everything clears, sequence repeats
        push(106, 3'b010, 1, 0, 0);
        push(123, 3'b011, 1, 0, 1);
        push(124, 3'b001, 1, 0, 2);
        push(153, 3'b101, 0, 1, 3);
        at_neg(105);
        restart = 1'b1;
        at_neg(106);
        restart = 1'b0;

        // reset mid-DOWN: outputs return to reset values without a clock edge
        push(161, 3'b101, 1, 0, 3);
        push(163, 3'b001, 1, 0, 2);
        push(166, 3'b010, 1, 0, 0);
        at_neg(160);
        shutdown = 1'b1;
        at_neg(165);
        reset_n  = 1'b0;
        shutdown = 1'b0;
        #1;
        nvec++;
        if (ch_out !== 3'b010 || seq_busy !== 1'b1 || seq_done !== 1'b0 ||
            step_idx !== 2'd0 || tick !== 1'b0) begin
            nerr++;
            $display("FAIL async_reset: got ch=%b busy=%b done=%b step=%0d tick=%b, want ch=010 busy=1 done=0 step=0 tick=0",
                     ch_out, seq_busy, seq_done, step_idx, tick);
        end

        at_neg(175);
        if (snap_q.size() != 0) begin
            nerr++;
            $display("FAIL snap missing: got %0d expected changes never seen, want 0", snap_q.size());
        end
        if (tick_q.size() != 0) begin
            nerr++;
            $display("FAIL tick missing: got %0d expected ticks never seen, want 0", tick_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
